// File: rtl/arb_grant_monitor.sv
// arb_grant_monitor: per-agent request/grant lifecycle tracker, grant counter, latency and protocol-error monitor
module arb_grant_monitor #(
    parameter int CNT_W        = 8,
    parameter int LAT_W        = 8,
    parameter int STARVE_LIMIT = 16
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             req_0_i,
    input  logic             req_1_i,
    input  logic             req_2_i,
    input  logic             req_3_i,
    input  logic             gnt_0_i,
    input  logic             gnt_1_i,
    input  logic             gnt_2_i,
    input  logic             gnt_3_i,
    input  logic             clr_i,
    input  logic [1:0]       sel_i,
    output logic [CNT_W-1:0] grant_count_o,
    output logic [LAT_W-1:0] max_latency_o,
    output logic             err_multi_o,
    output logic             err_spurious_o,
    output logic             err_starve_o,
    output logic [1:0]       starve_agent_o,
    output logic             busy_o
);
    typedef enum logic [1:0] {IDLE, WAIT, GRANTED} state_e;

    localparam logic [LAT_W-1:0] LIMIT   = LAT_W'(STARVE_LIMIT);
    localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           st_q   [4];
    state_e           st_d   [4];
    logic [LAT_W-1:0] wait_q [4];
    logic [LAT_W-1:0] wait_d [4];
    logic [LAT_W-1:0] lat_q  [4];
    logic [LAT_W-1:0] lat_d  [4];
    logic [CNT_W-1:0] cnt_q  [4];
    logic [CNT_W-1:0] cnt_d  [4];
    logic             multi_q, multi_d;
    logic             spur_q, spur_d;
    logic             starve_q, starve_d;
    logic [1:0]       sa_q, sa_d;
    logic             busy_q;
    logic [3:0]       req, gnt, hit;

    assign req = {req_3_i, req_2_i, req_1_i, req_0_i};
    assign gnt = {gnt_3_i, gnt_2_i, gnt_1_i, gnt_0_i};

    // next-state for agent FSMs, counters and sticky error flags; clr discards this cycle's events
    always_comb begin
        multi_d  = multi_q | ((gnt & (gnt - 4'd1)) != 4'd0);
        spur_d   = spur_q;
        starve_d = starve_q;
        sa_d     = sa_q;
        hit      = '0;
        for (int i = 0; i < 4; i++) begin
            st_d[i]   = st_q[i];
            wait_d[i] = wait_q[i];
            cnt_d[i]  = cnt_q[i];
            lat_d[i]  = lat_q[i];
            case (st_q[i])
                IDLE: begin
                    if (req[i]) begin
                        st_d[i]   = gnt[i] ? GRANTED : WAIT;
                        wait_d[i] = LAT_ONE;
                        if (gnt[i]) cnt_d[i] = (cnt_q[i] == '1) ? cnt_q[i] : cnt_q[i] + CNT_ONE;
                    end else if (gnt[i]) begin
                        spur_d = 1'b1;
                    end
                end
                WAIT: begin
                    if (gnt[i]) begin
                        st_d[i]  = GRANTED;
                        cnt_d[i] = (cnt_q[i] == '1) ? cnt_q[i] : cnt_q[i] + CNT_ONE;
                        lat_d[i] = (wait_q[i] > lat_q[i]) ? wait_q[i] : lat_q[i];
                    end else if (!req[i]) begin
                        st_d[i] = IDLE;
                    end else begin
                        wait_d[i] = (wait_q[i] == '1) ? wait_q[i] : wait_q[i] + LAT_ONE;
                    end
                    hit[i] = !gnt[i] && (wait_q[i] == LIMIT);
                end
                GRANTED: begin
                    if (!gnt[i]) begin
                        st_d[i]   = req[i] ? WAIT : IDLE;
                        wait_d[i] = LAT_ONE;
                    end
                end
                default: st_d[i] = IDLE;
            endcase
        end
        if (hit != 4'd0) begin
            starve_d = 1'b1;
            if (!starve_q) sa_d = hit[0] ? 2'd0 : hit[1] ? 2'd1 : hit[2] ? 2'd2 : 2'd3;
        end
        if (clr_i) begin
            multi_d  = 1'b0;
            spur_d   = 1'b0;
            starve_d = 1'b0;
            sa_d     = 2'd0;
            for (int i = 0; i < 4; i++) begin
                cnt_d[i] = '0;
                lat_d[i] = '0;
            end
        end
    end

    // state register; reset clears everything and returns all agents to IDLE
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            multi_q  <= 1'b0;
            spur_q   <= 1'b0;
            starve_q <= 1'b0;
            sa_q     <= 2'd0;
            busy_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                st_q[i]   <= IDLE;
                wait_q[i] <= '0;
                cnt_q[i]  <= '0;
                lat_q[i]  <= '0;
            end
        end else begin
            multi_q  <= multi_d;
            spur_q   <= spur_d;
            starve_q <= starve_d;
            sa_q     <= sa_d;
            busy_q   <= |gnt;
            for (int i = 0; i < 4; i++) begin
                st_q[i]   <= st_d[i];
                wait_q[i] <= wait_d[i];
                cnt_q[i]  <= cnt_d[i];
                lat_q[i]  <= lat_d[i];
            end
        end
    end

    assign grant_count_o  = cnt_q[sel_i];
    assign max_latency_o  = lat_q[sel_i];
    assign err_multi_o    = multi_q;
    assign err_spurious_o = spur_q;
    assign err_starve_o   = starve_q;
    assign starve_agent_o = sa_q;
    assign busy_o         = busy_q;
endmodule
